led_flash_sequencer: RTL and testbench

Converts single-event button pulses (for example, the output of the pushbutton debouncer) into human-visible, fixed-length LED flashes. The debouncer shortens a long press into one pulse; this block stretches one pulse back into a timed on/off pattern.
Every rising edge on the event input produces exactly one flash. Events that arrive while a flash is in progress are queued in a saturating counter and replayed back-to-back. It sits between the debounce stage and a board LED or status indicator.

---
 rtl/led_flash_sequencer.sv | 141 ++++++++++++++
 tb/tb_led_flash_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/led_flash_sequencer.sv
// Stretches single-cycle event pulses into fixed-length LED flashes and queues
// events that arrive mid-flash. Optional sticky overflow flag: LED_FLASH_OVF_FLAG_EN.
module led_flash_sequencer #(
  parameter int unsigned TICK_DIV  = 25000000,
  parameter int unsigned ON_TICKS  = 1,
  parameter int unsigned GAP_TICKS = 1,
  parameter int unsigned PEND_W    = 3
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              evt,
  output logic              led,
  output logic              busy,
`ifdef LED_FLASH_OVF_FLAG_EN
  output logic              ovf,
`endif
  output logic [PEND_W-1:0] pend_cnt
);

  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MAX_T    = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int unsigned TCNT_W   = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                evt_q;
  logic [PRE_W-1:0]    prescaler;
  logic [TCNT_W-1:0]   tick_cnt;
  logic                ev, tick, final_tick, want, start, from_q, inc, dec;
  logic                pend_nz, pend_full, drop;
  logic [PEND_W-1:0]   pend_d;
  logic                led_d, busy_d;

  assign ev        = evt & ~evt_q;
  assign tick      = (prescaler == PRE_W'(TICK_DIV - 1));
  assign pend_nz   = (pend_cnt != '0);
  assign pend_full = (pend_cnt == {PEND_W{1'b1}});
  assign want      = ev | pend_nz;

  // Final tick of the current phase, using the phase's own length.
  always_comb begin
    final_tick = 1'b0;
    if (state_q == ON)
      final_tick = tick && (tick_cnt == TCNT_W'(ON_TICKS - 1));
    else if (state_q == GAP)
      final_tick = tick && (tick_cnt == TCNT_W'(GAP_TICKS - 1));
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a start is any transition into ON
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: if (want) begin
        state_d = ON;
        start   = 1'b1;
      end
      ON: if (final_tick) state_d = GAP;
      GAP: if (final_tick) begin
        if (want) begin
          state_d = ON;
          start   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / pending-counter next values; queued events take priority on a start
  always_comb begin
    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
    from_q = start & pend_nz;
    dec    = from_q;
    inc    = ev & ~(start & ~pend_nz);
    drop   = 1'b0;
    pend_d = pend_cnt;
    case ({inc, dec})
      2'b10: begin
        if (pend_full) drop   = 1'b1;
        else           pend_d = pend_cnt + PEND_W'(1);
      end
      2'b01:   pend_d = pend_cnt - PEND_W'(1);
      default: pend_d = pend_cnt;
    endcase
  end

  // Prescaler and tick counter restart on every state entry and idle
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      tick_cnt  <= '0;
    end else if ((state_d != state_q) || (state_q == IDLE)) begin
      prescaler <= '0;
      tick_cnt  <= '0;
    end else if (tick) begin
      prescaler <= '0;
      tick_cnt  <= tick_cnt + TCNT_W'(1);
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      evt_q    <= 1'b0;
      led      <= 1'b0;
      busy     <= 1'b0;
      pend_cnt <= '0;
    end else begin
      evt_q    <= evt;
      led      <= led_d;
      busy     <= busy_d;
      pend_cnt <= pend_d;
    end
  end

`ifdef LED_FLASH_OVF_FLAG_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_led_flash_sequencer.sv
// Randomized and directed bench for led_flash_sequencer against a slot-position
// reference model (one flash = one fixed-length slot of ON then GAP cycles).
module tb_led_flash_sequencer;

  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned ON_TICKS  = 2;
  localparam int unsigned GAP_TICKS = 1;
  localparam int unsigned PEND_W    = 2;
  localparam int MAX_PEND = (1 << PEND_W) - 1;
  localparam int ON_CYC   = ON_TICKS * TICK_DIV;
  localparam int SLOT     = (ON_TICKS + GAP_TICKS) * TICK_DIV;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic evt    = 1'b0;
  logic led, busy;
  logic [PEND_W-1:0] pend_cnt;
`ifdef LED_FLASH_OVF_FLAG_EN
  logic ovf;
`endif

  led_flash_sequencer #(
    .TICK_DIV(TICK_DIV), .ON_TICKS(ON_TICKS), .GAP_TICKS(GAP_TICKS), .PEND_W(PEND_W)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .evt(evt), .led(led), .busy(busy),
`ifdef LED_FLASH_OVF_FLAG_EN
    .ovf(ovf),
`endif
    .pend_cnt(pend_cnt)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_busy = 0, m_pos = 0, m_pend = 0, m_evt_q = 0, m_ovf = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_led();
    return (m_busy != 0 && m_pos < ON_CYC) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_pos = 0; m_pend = 0; m_evt_q = 0; m_ovf = 0;
  endtask

  // One clock edge of the model: a flash may start when idle or in the last slot cycle
  task automatic model_edge();
    int ev, can, start, from_q, inc, n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ev      = (evt && !m_evt_q) ? 1 : 0;
    m_evt_q = evt ? 1 : 0;
    can     = (m_busy == 0 || m_pos == SLOT - 1) ? 1 : 0;
    start   = (can != 0 && (ev != 0 || m_pend > 0)) ? 1 : 0;
    from_q  = (start != 0 && m_pend > 0) ? 1 : 0;
    inc     = (ev != 0 && !(start != 0 && from_q == 0)) ? 1 : 0;
    if (start != 0) begin
      m_busy = 1; m_pos = 0;
    end else if (m_busy != 0) begin
      if (m_pos == SLOT - 1) m_busy = 0;
      else m_pos++;
    end
    n = m_pend - from_q + inc;
    if (n > MAX_PEND) begin
      n = MAX_PEND;
      m_ovf = 1;
    end
    m_pend = n;
  endtask

  task automatic compare_all();
    check("led", int'(led), m_led());
    check("busy", int'(busy), m_busy);
    check("pend_cnt", int'(pend_cnt), m_pend);
`ifdef LED_FLASH_OVF_FLAG_EN
    check("ovf", int'(ovf), m_ovf);
`endif
  endtask

  // Advance one cycle: model follows the edge, outputs sampled at the next falling edge
  task automatic step();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse();
    evt = 1'b1; step();
    evt = 1'b0; step();
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_led"}, int'(led), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_pend"}, int'(pend_cnt), 0);
  endtask

  int led_cycles;
  int max_pend;

  initial begin
    @(negedge clk_in);
    @(negedge clk_in);
    compare_all();
    check("reset_led", int'(led), 0);
    check("reset_pend", int'(pend_cnt), 0);
    rst_n = 1'b1;
    steps(3);

    // Single press held for 10 cycles: one 8-cycle flash, then 4-cycle gap
    led_cycles = 0;
    evt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      led_cycles += int'(led);
      if (i == 0) check("latency_led", int'(led), 1);
    end
    evt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      led_cycles += int'(led);
    end
    check("single_led_cycles", led_cycles, ON_CYC);
    check("single_idle", int'(busy), 0);

    // Queued replay: press + 3 edges during ON -> 4 back-to-back flashes
    max_pend = 0;
    pulse(); pulse(); pulse(); pulse();
    max_pend = int'(pend_cnt);
    check("queue_depth", max_pend, 3);
    steps(4 * SLOT);
    check("queue_drained", int'(busy), 0);

    // Saturation: press + 5 edges
    pulse();
    for (int i = 0; i < 5; i++) pulse();
    check("sat_pend", int'(pend_cnt), MAX_PEND);
`ifdef LED_FLASH_OVF_FLAG_EN
    check("sat_ovf", int'(ovf), 1);
`endif
    steps(5 * SLOT);
    check("sat_idle", int'(busy), 0);

    // Boundary: new edge on the final gap cycle restarts ON directly
    evt = 1'b1; step();
    evt = 1'b0; steps(SLOT - 1);
    evt = 1'b1; step();
    check("boundary_led", int'(led), 1);
    check("boundary_pend", int'(pend_cnt), 0);
    evt = 1'b0; steps(SLOT + 2);

    // Async reset mid-ON with two queued events
    pulse(); pulse(); pulse();
    check("pre_reset_pend", int'(pend_cnt), 2);
    check("pre_reset_led", int'(led), 1);
    async_reset_check("mid_on_reset");
    steps(3);
    rst_n = 1'b1;
    steps(2 * SLOT);
    check("post_reset_quiet", int'(busy), 0);

    // Reset release with evt held high: exactly one flash
    async_reset_check("evt_high_reset");
    evt = 1'b1;
    steps(2);
    rst_n = 1'b1;
    led_cycles = 0;
    step();
    check("release_first_led", int'(led), 1);
    led_cycles += int'(led);
    for (int i = 0; i < 3 * SLOT; i++) begin
      step();
      led_cycles += int'(led);
    end
    check("release_one_flash", led_cycles, ON_CYC);
    evt = 1'b0;
    steps(2);

    // Randomized traffic with occasional async resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset_check("rand_reset");
        step();
        rst_n = 1'b1;
      end
      evt = ($urandom_range(0, 5) == 0) ? ~evt : evt;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
